// File: rtl/led_switch_pkg.sv
// Shared definitions for the switch input path.
//   DEFAULT_WIDTH : default number of board switches
//   dbc_state_e   : event-stream FSM states
//   cnt_width()   : debounce counter width for a given cycle count
package led_switch_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } dbc_state_e;

  // Counter must hold 0..cycles; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// Single-switch synchroniser + debouncer.
//   clk, rst : clock, synchronous active-high reset
//   raw      : asynchronous pin
//   stable   : debounced level (registered)
//   flip     : stable inverts at the coming edge (combinational)
module debounce_bit
  import led_switch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic flip
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s    = sync[SYNC_STAGES-1];
  // Counter already shows DEBOUNCE_CYCLES-1 earlier differing cycles, so
  // this cycle completes the run.
  assign flip = (s != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (s == stable || flip) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
      if (flip) stable <= ~stable;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounced switch vector with a valid/ready change-event stream.
//   clk, rst        : clock, synchronous active-high reset
//   switches_raw    : asynchronous switch pins
//   switches_stable : debounced switch state
//   change_valid    : event available; held until accepted
//   change_ready    : consumer accepts event
//   change_data     : switches_stable snapshot at event load
//   change_mask     : bits that flipped since previous accepted event
module switch_debouncer
  import led_switch_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches_stable,
  output logic             change_valid,
  input  logic             change_ready,
  output logic [WIDTH-1:0] change_data,
  output logic [WIDTH-1:0] change_mask
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "switch_debouncer: WIDTH must be > 0");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "switch_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $fatal(1, "switch_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] stab, f, nxt, pend;
  dbc_state_e       state;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (switches_raw[i]),
      .stable(stab[i]),
      .flip  (f[i])
    );
  end

  assign switches_stable = stab;
  // Value switches_stable takes at this edge; events snapshot this.
  assign nxt = stab ^ f;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      change_valid <= 1'b0;
      change_data  <= '0;
      change_mask  <= '0;
      pend         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|f) begin
            change_valid <= 1'b1;
            change_data  <= nxt;
            change_mask  <= f;
            state        <= PRESENT;
          end
        end
        PRESENT: begin
          if (change_ready) begin
            // Flips gathered during the stall plus any landing right now
            // become the next event without a bubble.
            if (|(pend | f)) begin
              change_data <= nxt;
              change_mask <= pend | f;
              pend        <= '0;
            end else begin
              change_valid <= 1'b0;
              change_mask  <= '0;
              state        <= IDLE;
            end
          end else begin
            pend <= pend | f;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw, raw2;
  logic       rdy, rdy2;
  logic [7:0] st0, d0, m0, st1, d1, m1;
  logic       v0, v1;

  int total = 0;
  int bad   = 0;
  int ev    = 0;
  logic pv0 = 1'b0;
  bit   model_on = 1'b0;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .switches_raw(raw), .switches_stable(st0),
    .change_valid(v0), .change_ready(rdy), .change_data(d0), .change_mask(m0));

  switch_debouncer #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .switches_raw(raw2), .switches_stable(st1),
    .change_valid(v1), .change_ready(rdy2), .change_data(d1), .change_mask(m1));

  // ---------------- behavioural model ----------------
  // hist[u][k] = raw sampled k+1 edges ago. A bit's stable value flips at an
  // edge when the synced value (raw delayed by SYNC edges) disagreed with it
  // on each of the last DEB edges.
  logic [7:0] hist [2][16];
  logic [7:0] mst [2];
  logic       mval [2];
  logic [7:0] mdat [2];
  logic [7:0] mmsk [2];
  logic [7:0] macc [2];

  task automatic step(input int u, input int deb, input logic r,
                      input logic [7:0] rv, input logic rd);
    logic [7:0] f, nst;
    if (r) begin
      for (int k = 0; k < 16; k++) hist[u][k] = 8'h00;
      mst[u] = 0; mval[u] = 0; mdat[u] = 0; mmsk[u] = 0; macc[u] = 0;
      return;
    end
    f = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit all_diff = 1'b1;
      for (int j = SYNC; j < SYNC + deb; j++)
        if (hist[u][j-1][i] == mst[u][i]) all_diff = 1'b0;
      f[i] = all_diff;
    end
    nst = mst[u] ^ f;
    if (!mval[u]) begin
      if (f != 0) begin mval[u] = 1; mdat[u] = nst; mmsk[u] = f; end
    end else if (rd) begin
      if ((macc[u] | f) != 0) begin
        mdat[u] = nst; mmsk[u] = macc[u] | f; macc[u] = 0;
      end else begin
        mval[u] = 0; mmsk[u] = 0;
      end
    end else begin
      macc[u] = macc[u] | f;
    end
    for (int k = 15; k > 0; k--) hist[u][k] = hist[u][k-1];
    hist[u][0] = rv;
    mst[u] = nst;
  endtask

  always @(posedge clk) begin
    if (rst) model_on <= 1'b1;
    step(0, 4, rst, raw, rdy);
    step(1, 1, rst, raw2, rdy2);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, plus event counting for dut0
  always @(negedge clk) begin
    if (model_on) begin
      chk("m0.stable", st0, mst[0]);
      chk("m0.valid", {7'd0, v0}, {7'd0, mval[0]});
      chk("m0.mask", m0, mmsk[0]);
      if (mval[0]) chk("m0.data", d0, mdat[0]);
      chk("m1.stable", st1, mst[1]);
      chk("m1.valid", {7'd0, v1}, {7'd0, mval[1]});
      chk("m1.mask", m1, mmsk[1]);
      if (mval[1]) chk("m1.data", d1, mdat[1]);
    end
    if (v0 && !pv0) ev++;
    pv0 = v0;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    raw = 8'h00; raw2 = 8'h00; rdy = 1'b1; rdy2 = 1'b1;
    rst = 1'b1; tick(2); rst = 1'b0; ev = 0;
  endtask

  initial begin
    rst = 1'b1; raw = 8'h00; raw2 = 8'h00; rdy = 1'b1; rdy2 = 1'b1;
    tick(3);
    chk("rst.stable", st0, 8'h00);
    chk("rst.valid", {7'd0, v0}, 8'h00);
    chk("rst.mask", m0, 8'h00);
    rst = 1'b0; ev = 0;

    // 1. clean step
    raw = 8'h21;
    tick(5); chk("t1.early", st0, 8'h00);
    tick(1); chk("t1.stable", st0, 8'h21);
    chk("t1.valid", {7'd0, v0}, 8'h01);
    chk("t1.data", d0, 8'h21);
    chk("t1.mask", m0, 8'h21);
    tick(1); chk("t1.drop", {7'd0, v0}, 8'h00);

    // 2. glitch 3 cycles rejected, 4 cycles accepted
    do_reset();
    raw = 8'h01; tick(3); raw = 8'h00; tick(10);
    chk("t2.g3.stable", st0, 8'h00);
    chk("t2.g3.events", ev[7:0], 8'h00);
    raw = 8'h01; tick(4); raw = 8'h00; tick(2);
    chk("t2.g4.stable", st0, 8'h01);
    chk("t2.g4.mask", m0, 8'h01);
    tick(2); chk("t2.g4.events", ev[7:0], 8'h01);

    // 3. backpressure with coalescing
    do_reset();
    rdy = 1'b0; raw = 8'h02; tick(6);
    chk("t3.ev1.valid", {7'd0, v0}, 8'h01);
    chk("t3.ev1.data", d0, 8'h02);
    chk("t3.ev1.mask", m0, 8'h02);
    raw = 8'h80; tick(8);
    chk("t3.hold.data", d0, 8'h02);
    chk("t3.hold.mask", m0, 8'h02);
    chk("t3.hold.stable", st0, 8'h80);
    rdy = 1'b1; tick(1); rdy = 1'b0;
    chk("t3.ev2.valid", {7'd0, v0}, 8'h01);
    chk("t3.ev2.data", d0, 8'h80);
    chk("t3.ev2.mask", m0, 8'h82);
    rdy = 1'b1; tick(1);
    chk("t3.drop", {7'd0, v0}, 8'h00);

    // 4. handshake coincides with a new flip: no bubble
    do_reset();
    raw = 8'h04; tick(1); raw = 8'h0C; tick(5);
    chk("t4.ev1.mask", m0, 8'h04);
    tick(1);
    chk("t4.ev2.valid", {7'd0, v0}, 8'h01);
    chk("t4.ev2.data", d0, 8'h0C);
    chk("t4.ev2.mask", m0, 8'h08);
    tick(1); chk("t4.drop", {7'd0, v0}, 8'h00);

    // 5. reset during a stalled event and a running debounce
    do_reset();
    rdy = 1'b0; raw = 8'h01; tick(6);
    chk("t5.stall.valid", {7'd0, v0}, 8'h01);
    raw = 8'h21; tick(2);
    rst = 1'b1; raw = 8'h20; tick(1);
    chk("t5.rst.stable", st0, 8'h00);
    chk("t5.rst.valid", {7'd0, v0}, 8'h00);
    chk("t5.rst.data", d0, 8'h00);
    chk("t5.rst.mask", m0, 8'h00);
    rst = 1'b0; rdy = 1'b1; tick(5);
    chk("t5.early", st0, 8'h00);
    tick(1);
    chk("t5.valid", {7'd0, v0}, 8'h01);
    chk("t5.mask", m0, 8'h20);
    chk("t5.data", d0, 8'h20);

    // 6. DEBOUNCE_CYCLES=1
    do_reset();
    raw2 = 8'hFF; tick(2);
    chk("t6.early", st1, 8'h00);
    tick(1);
    chk("t6.stable", st1, 8'hFF);
    chk("t6.valid", {7'd0, v1}, 8'h01);
    chk("t6.mask", m1, 8'hFF);
    chk("t6.data", d1, 8'hFF);
    tick(1); chk("t6.drop", {7'd0, v1}, 8'h00);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
